// File: rtl/i2s_pkg.sv
// Types and constants shared by the I2S receive and transmit paths.
package i2s_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_t;

  localparam logic I2S_LEFT = 1'b0;

endpackage

// File: rtl/i2s_pin_sync.sv
// Synchronises bclk/wclk/sdin through one shared flop chain so all three stay
// aligned, and flags the synchronised bclk rising edge as a bit event.
module i2s_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic bclk,
  input  logic wclk,
  input  logic sdin,
  output logic bitEvent,
  output logic wclkS,
  output logic sdinS
);

  // bit 2 = bclk, bit 1 = wclk, bit 0 = sdin
  logic [2:0] sync_q [SYNC_STAGES];
  logic       bclk_last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      bclk_last_q <= 1'b0;
    end else begin
      sync_q[0] <= {bclk, wclk, sdin};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      bclk_last_q <= sync_q[SYNC_STAGES-1][2];
    end
  end

  assign bitEvent = sync_q[SYNC_STAGES-1][2] & ~bclk_last_q;
  assign wclkS    = sync_q[SYNC_STAGES-1][1];
  assign sdinS    = sync_q[SYNC_STAGES-1][0];

endmodule

// File: rtl/i2s_receiver.sv
// I2S capture: deserialises sdin into left/right words (1-bit delay framing)
// and hands completed pairs out through a valid/ready holding register.
//
//   state | meaning
//   SYNC  | discarding bits, waiting for wclk 1->0 to align to a left slot
//   LEFT  | shifting the left word
//   RIGHT | shifting the right word; wclk 1->0 completes the pair
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             bclk,
  input  logic             wclk,
  input  logic             sdin,
  output logic             sampleValid,
  input  logic             sampleReady,
  output logic [WIDTH-1:0] leftSample,
  output logic [WIDTH-1:0] rightSample,
  output logic             overflow,
  input  logic             clearOverflow
);

  localparam int CW = $clog2(WIDTH + 1);

  logic bitEvent, wclkS, sdinS;

  i2s_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk     (clk),
    .reset   (reset),
    .bclk    (bclk),
    .wclk    (wclk),
    .sdin    (sdin),
    .bitEvent(bitEvent),
    .wclkS   (wclkS),
    .sdinS   (sdinS)
  );

  i2s_state_t       state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             wclk_last_q, wclk_last_d;
  logic [WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic             pair_done_q, pair_done_d;
  logic [WIDTH-1:0] pair_left_q, pair_left_d, pair_right_q, pair_right_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] left_out_q, left_out_d, right_out_q, right_out_d;
  logic             ovf_q, ovf_d;
  logic             slot_change, ovf_set;

  assign slot_change = wclkS != wclk_last_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    wclk_last_d  = wclk_last_q;
    left_d       = left_q;
    right_d      = right_q;
    pair_done_d  = 1'b0;
    pair_left_d  = pair_left_q;
    pair_right_d = pair_right_q;

    if (bitEvent) begin
      wclk_last_d = wclkS;
      if (enable) begin
        if (bit_cnt_q < CW'(WIDTH)) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt_q == CW'(WIDTH - 1 - i)) begin
              if (state_q == LEFT) left_d[i] = sdinS;
              else if (state_q == RIGHT) right_d[i] = sdinS;
            end
          end
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
        // The slot-change bit belongs to the outgoing channel, so the pair is
        // captured from the already-updated words before the incoming clear.
        if (slot_change) begin
          bit_cnt_d = '0;
          case (state_q)
            SYNC: begin
              if (wclkS == I2S_LEFT) begin
                state_d = LEFT;
                left_d  = '0;
              end
            end
            LEFT: begin
              state_d = RIGHT;
              right_d = '0;
            end
            RIGHT: begin
              state_d      = LEFT;
              pair_done_d  = 1'b1;
              pair_left_d  = left_d;
              pair_right_d = right_d;
              left_d       = '0;
            end
            default: state_d = SYNC;
          endcase
        end
      end
    end

    if (!enable) begin
      state_d   = SYNC;
      bit_cnt_d = '0;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    left_out_d  = left_out_q;
    right_out_d = right_out_q;
    ovf_set     = 1'b0;

    if (pair_done_q) begin
      if (!valid_q || sampleReady) begin
        valid_d     = 1'b1;
        left_out_d  = pair_left_q;
        right_out_d = pair_right_q;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (valid_q && sampleReady) begin
      valid_d = 1'b0;
    end

    ovf_d = ovf_q;
    if (ovf_set) ovf_d = 1'b1;
    else if (clearOverflow) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SYNC;
      bit_cnt_q    <= '0;
      wclk_last_q  <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      pair_done_q  <= 1'b0;
      pair_left_q  <= '0;
      pair_right_q <= '0;
      valid_q      <= 1'b0;
      left_out_q   <= '0;
      right_out_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      wclk_last_q  <= wclk_last_d;
      left_q       <= left_d;
      right_q      <= right_d;
      pair_done_q  <= pair_done_d;
      pair_left_q  <= pair_left_d;
      pair_right_q <= pair_right_d;
      valid_q      <= valid_d;
      left_out_q   <= left_out_d;
      right_out_q  <= right_out_d;
      ovf_q        <= ovf_d;
    end
  end

  assign sampleValid = valid_q;
  assign leftSample  = left_out_q;
  assign rightSample = right_out_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/i2s_receiver.md
Name: i2s_receiver

Overview:
- Capture side of the audio codec serial link: deserialises the codec's ADC data line (sdin) into stereo sample pairs.
- bclk and wclk come from the SoC's own I2S clock generator (same clk domain, but treated as asynchronous pins and oversampled).
- Delivers left/right words to the SoC audio FIFO through a valid/ready interface, with a sticky overflow flag.

Parameters:
- WIDTH, 24, sample word width; bits captured MSB-first per channel.
- SYNC_STAGES, 2, synchroniser depth for bclk/wclk/sdin (min 2).

Ports:
- clk  input  1  system clock (50 MHz); all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  receiver enable; low forces SYNC state.
- bclk  input  1  I2S bit clock; high and low phases each ≥ SYNC_STAGES+1 clk periods.
- wclk  input  1  I2S word select; 0 = left, 1 = right; changes on bclk falling edge.
- sdin  input  1  serial data from codec; changes on bclk falling edge.
- sampleValid  output  1  holding register contains an unconsumed pair.
- sampleReady  input  1  consumer accepts the pair when sampleValid && sampleReady.
- leftSample  output  WIDTH  left word of the held pair.
- rightSample  output  WIDTH  right word of the held pair.
- overflow  output  1  sticky: a completed pair was dropped.
- clearOverflow  input  1  single-cycle pulse clears overflow.

Behaviour:
- Reset (async, active-high) clears all state: state = SYNC, counters 0, shift words 0, sampleValid 0, leftSample 0, rightSample 0, overflow 0.
- Synchronisation: bclk, wclk and sdin each pass through SYNC_STAGES flops so they stay aligned. A bclk rising edge is detected when the synchronised bclk = 1 and its previous value = 0. Only on such "bit events" are wclkS and sdinS used.
- wclkLast is updated at every bit event.
- Standard I2S, 1-bit delay: the bit event at which wclkS != wclkLast carries the LSB slot bit of the outgoing channel. The next bit event carries the MSB of the new channel.
- Bit write, for every bit event while enabled: if bitCount < WIDTH, write sdinS to the active channel word at index WIDTH-1-bitCount. bitCount saturates at WIDTH.
  - Slots longer than WIDTH: excess bits are ignored.
  - Slots shorter than WIDTH: the word is left-aligned with zero-padded LSBs, because the channel word is cleared to 0 when its slot starts.
- Slot change (wclkS != wclkLast): the bit is written to the outgoing channel first. Then bitCount is set to 0, the incoming channel word is cleared, and the state changes.
- States:
  - SYNC: discard bits; on wclk 1→0 go to LEFT (no pair emitted).
  - LEFT: on wclk 0→1 go to RIGHT.
  - RIGHT: on wclk 1→0 go to LEFT and raise pairDone for one cycle.
  - Any state: enable low → SYNC, bitCount 0.
- Output register:
  - pairDone is registered one cycle after the bit event.
  - sampleValid rises 3 clk cycles after the clk edge at which the first synchroniser flop captures the bclk rising edge that ends the right slot (SYNC_STAGES=2).
  - pairDone with sampleValid = 0, or with sampleValid && sampleReady in the same cycle: load both words; sampleValid = 1.
  - pairDone with sampleValid && !sampleReady: new pair dropped, held pair unchanged, overflow set.
  - Handshake without pairDone: sampleValid → 0; data outputs hold their last value.
- overflow: cleared by clearOverflow. If set and clear occur in the same cycle, set wins.
- enable deassert mid-frame: the partial pair is discarded; the held pair stays readable and drainable. Re-enable resynchronises on the next wclk 1→0.
- Reset mid-operation: immediate clear per reset values; no spurious sampleValid after release.

Decomposition:
- Shared package i2s_pkg holds:
  - typedef enum i2s_state_t {SYNC, LEFT, RIGHT}, so the existing I2S transmitter can share it.
  - Constant I2S_LEFT = 1'b0 for wclk polarity.
- One sub-module, i2s_pin_sync: SYNC_STAGES-deep synchroniser for {bclk, wclk, sdin} plus bclk rising-edge detect. Outputs bitEvent, wclkS, sdinS.

Test Plan:
- 32-bit slots, bclk = clk/16, left 0xABCDEF, right 0x123456 (8 trailing zero bits each) → after the first full frame following sync: leftSample = 0xABCDEF, rightSample = 0x123456, one valid pulse per frame.
- 16-bit slots, left 0x8001, right 0x7FFE → leftSample = 0x800100, rightSample = 0x7FFE00 (zero-padded LSBs).
- sampleReady held 0 across two frames → first pair retained, overflow = 1. clearOverflow pulsed in the same cycle as a third drop → overflow stays 1. Pulse clearOverflow alone → overflow = 0.
- enable deasserted mid-right-slot, reasserted mid-left-slot → no pair until one full left+right after the next wclk 1→0. Previously held pair still drains.
- Reset asserted mid-frame for 1 cycle → all outputs 0 immediately. First valid pair only after a complete new frame.
- sampleReady = 1 continuously, 32-bit slots → sampleValid high 1 cycle per frame, exactly 3 clk cycles after the bclk rising edge that ends the right slot. No overflow.
